misao_mem_arbiter: RTL and testbench

Single-port memory arbiter for the MISA-O core. It shares the one 8-bit, 15-bit-addressed memory between the core's fetch/load/store port and a DMA/debug-loader port. The core has priority, and a starvation timer guarantees the DMA port a bounded burst window. The block sits between `misao` and the memory model or SRAM, and adds a stall output to the core.

---
 rtl/misao_mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_misao_mem_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/misao_mem_arbiter.sv
// Single-port memory arbiter for the MISA-O core: core has priority, a starvation
// timer forces bounded DMA burst windows onto the shared 8-bit memory.
module misao_mem_arbiter #(
    parameter int ADDR_W        = 15,
    parameter int DATA_W        = 8,
    parameter int STARVE_LIMIT  = 4,
    parameter int DMA_MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_enable_read,
    input  logic              core_enable_write,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_data_out,
    output logic [DATA_W-1:0] core_data_in,
    output logic              core_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              mem_enable_read,
    output logic              mem_enable_write,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic [DATA_W-1:0] mem_data_in
);

    localparam int WAIT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam int BEAT_W = (DMA_MAX_BURST > 1) ? $clog2(DMA_MAX_BURST) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STARVE_LIMIT - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(DMA_MAX_BURST - 1);

    typedef enum logic [0:0] {
        CORE_PRI = 1'b0,
        DMA_WIN  = 1'b1
    } arb_state_t;

    arb_state_t          state_r;
    arb_state_t          state_nxt_s;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_nxt_s;
    logic [BEAT_W-1:0]   beat_cnt_r;
    logic [BEAT_W-1:0]   beat_cnt_nxt_s;
    logic [DATA_W-1:0]   dma_rdata_r;
    logic                dma_rvalid_r;
    logic                core_req_s;
    logic                core_rd_s;
    logic                core_gnt_s;
    logic                dma_gnt_s;

    // When both core enables are set the write wins and the read is dropped.
    assign core_req_s = core_enable_read | core_enable_write;
    assign core_rd_s  = core_enable_read & ~core_enable_write;

    // Grant decision from registered state and current requests; nothing is granted in reset.
    always_comb begin
        core_gnt_s = 1'b0;
        dma_gnt_s  = 1'b0;
        if (!rst) begin
            core_gnt_s = 1'b0;
            dma_gnt_s  = 1'b0;
        end else begin
            case (state_r)
                CORE_PRI: begin
                    core_gnt_s = core_req_s;
                    dma_gnt_s  = dma_req & ~core_req_s;
                end
                DMA_WIN: begin
                    core_gnt_s = 1'b0;
                    dma_gnt_s  = dma_req;
                end
                default: begin
                    core_gnt_s = 1'b0;
                    dma_gnt_s  = 1'b0;
                end
            endcase
        end
    end

    // Next-state and counter update for the starvation timer and burst window.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        beat_cnt_nxt_s = beat_cnt_r;
        case (state_r)
            CORE_PRI: begin
                beat_cnt_nxt_s = {BEAT_W{1'b0}};
                if (dma_req && !dma_gnt_s) begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_nxt_s    = DMA_WIN;
                        wait_cnt_nxt_s = {WAIT_W{1'b0}};
                    end else begin
                        wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
                    end
                end else begin
                    wait_cnt_nxt_s = {WAIT_W{1'b0}};
                end
            end
            DMA_WIN: begin
                wait_cnt_nxt_s = {WAIT_W{1'b0}};
                if (dma_gnt_s) begin
                    if (beat_cnt_r == BEAT_LAST) begin
                        state_nxt_s    = CORE_PRI;
                        beat_cnt_nxt_s = {BEAT_W{1'b0}};
                    end else begin
                        beat_cnt_nxt_s = beat_cnt_r + BEAT_W'(1);
                    end
                end else begin
                    // DMA let go: window closes, counters do not carry over.
                    state_nxt_s    = CORE_PRI;
                    beat_cnt_nxt_s = {BEAT_W{1'b0}};
                end
            end
            default: begin
                state_nxt_s    = CORE_PRI;
                wait_cnt_nxt_s = {WAIT_W{1'b0}};
                beat_cnt_nxt_s = {BEAT_W{1'b0}};
            end
        endcase
    end

    // State, counters and DMA read-return registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= CORE_PRI;
            wait_cnt_r   <= {WAIT_W{1'b0}};
            beat_cnt_r   <= {BEAT_W{1'b0}};
            dma_rdata_r  <= {DATA_W{1'b0}};
            dma_rvalid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            wait_cnt_r   <= wait_cnt_nxt_s;
            beat_cnt_r   <= beat_cnt_nxt_s;
            dma_rvalid_r <= dma_gnt_s & ~dma_we;
            if (dma_gnt_s && !dma_we) begin
                dma_rdata_r <= mem_data_in;
            end else begin
                dma_rdata_r <= dma_rdata_r;
            end
        end
    end

    // Memory-side mux: the granted port drives address, data and strobes.
    always_comb begin
        mem_enable_read  = 1'b0;
        mem_enable_write = 1'b0;
        mem_rw           = 1'b0;
        mem_addr         = {ADDR_W{1'b0}};
        mem_data_out     = {DATA_W{1'b0}};
        core_data_in     = {DATA_W{1'b0}};
        if (core_gnt_s) begin
            mem_enable_read  = core_rd_s;
            mem_enable_write = core_enable_write;
            mem_rw           = core_enable_write;
            mem_addr         = core_addr;
            mem_data_out     = core_data_out;
            core_data_in     = core_rd_s ? mem_data_in : {DATA_W{1'b0}};
        end else if (dma_gnt_s) begin
            mem_enable_read  = ~dma_we;
            mem_enable_write = dma_we;
            mem_rw           = dma_we;
            mem_addr         = dma_addr;
            mem_data_out     = dma_wdata;
        end else begin
            mem_enable_read  = 1'b0;
            mem_enable_write = 1'b0;
        end
    end

    assign core_stall = rst & core_req_s & ~core_gnt_s;
    assign dma_gnt    = dma_gnt_s;
    assign dma_rdata  = dma_rdata_r;
    assign dma_rvalid = dma_rvalid_r;

endmodule

// File: tb/tb_misao_mem_arbiter.sv
// Directed bench for misao_mem_arbiter: vector table for single-cycle behaviour
// plus hand sequences for starvation windows, window exit and reset abort.
module tb_misao_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_enable_read, core_enable_write;
    logic [14:0] core_addr;
    logic [7:0]  core_data_out, core_data_in;
    logic        core_stall;
    logic        dma_req, dma_we;
    logic [14:0] dma_addr;
    logic [7:0]  dma_wdata, dma_rdata;
    logic        dma_gnt, dma_rvalid;
    logic        mem_enable_read, mem_enable_write, mem_rw;
    logic [14:0] mem_addr;
    logic [7:0]  mem_data_out, mem_data_in;

    logic [7:0]  mem [0:32767];
    logic        preload = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    misao_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .core_enable_read(core_enable_read), .core_enable_write(core_enable_write),
        .core_addr(core_addr), .core_data_out(core_data_out),
        .core_data_in(core_data_in), .core_stall(core_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_enable_read(mem_enable_read), .mem_enable_write(mem_enable_write),
        .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
        .mem_data_in(mem_data_in)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write on the rising edge.
    assign mem_data_in = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_enable_write) begin
            mem[mem_addr] <= mem_data_out;
        end else if (preload) begin
            mem[15'h0003] <= 8'hA0;
            mem[15'h0010] <= 8'h5C;
        end
    end

    typedef struct {
        logic        rst, rd, wr;
        logic [14:0] addr;
        logic [7:0]  cdo;
        logic        dreq, dwe;
        logic [14:0] daddr;
        logic [7:0]  dwd;
        logic        stall, gnt, mer, mew, rw;
        logic [14:0] maddr;
        logic [7:0]  mdo, cdi;
        logic        rvalid;
        logic [7:0]  rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic rd, input logic wr, input logic [14:0] a,
                         input logic [7:0] cdo, input logic dq, input logic dw,
                         input logic [14:0] da, input logic [7:0] dd);
        rst = r; core_enable_read = rd; core_enable_write = wr; core_addr = a;
        core_data_out = cdo; dma_req = dq; dma_we = dw; dma_addr = da; dma_wdata = dd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic rd, input logic wr, input logic [14:0] a,
                                input logic [7:0] cdo, input logic dq, input logic dw,
                                input logic [14:0] da, input logic [7:0] dd,
                                input logic st, input logic g, input logic er, input logic ew,
                                input logic rw, input logic [14:0] ma, input logic [7:0] mdo,
                                input logic [7:0] cdi, input logic rv, input logic [7:0] rdt);
        vec_t v;
        v.rst = r; v.rd = rd; v.wr = wr; v.addr = a; v.cdo = cdo;
        v.dreq = dq; v.dwe = dw; v.daddr = da; v.dwd = dd;
        v.stall = st; v.gnt = g; v.mer = er; v.mew = ew; v.rw = rw;
        v.maddr = ma; v.mdo = mdo; v.cdi = cdi; v.rvalid = rv; v.rdata = rdt;
        return v;
    endfunction

    initial begin
        // reset held 3 cycles with core read and DMA request pending
        vecs[0] = mk(1'b0,1'b1,1'b0,15'h0003,8'h00,1'b1,1'b0,15'h0010,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,15'h0000,8'h00,8'h00,1'b0,8'h00);
        vecs[1] = vecs[0];
        vecs[2] = vecs[0];
        // core-only read of 0x0003
        vecs[3] = mk(1'b1,1'b1,1'b0,15'h0003,8'h00,1'b0,1'b0,15'h0010,8'h00, 1'b0,1'b0,1'b1,1'b0,1'b0,15'h0003,8'h00,8'hA0,1'b0,8'h00);
        // core idle, opportunistic DMA read of 0x0010
        vecs[4] = mk(1'b1,1'b0,1'b0,15'h0000,8'h00,1'b1,1'b0,15'h0010,8'h00, 1'b0,1'b1,1'b1,1'b0,1'b0,15'h0010,8'h00,8'h00,1'b0,8'h00);
        vecs[5] = mk(1'b1,1'b0,1'b0,15'h0000,8'h00,1'b0,1'b0,15'h0000,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,15'h0000,8'h00,8'h00,1'b1,8'h5C);
        vecs[6] = mk(1'b1,1'b0,1'b0,15'h0000,8'h00,1'b0,1'b0,15'h0000,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,15'h0000,8'h00,8'h00,1'b0,8'h5C);
        // both core enables: write wins
        vecs[7] = mk(1'b1,1'b1,1'b1,15'h0008,8'h3E,1'b0,1'b0,15'h0000,8'h00, 1'b0,1'b0,1'b0,1'b1,1'b1,15'h0008,8'h3E,8'h00,1'b0,8'h5C);
        // opportunistic DMA write leaves dma_rdata untouched
        vecs[8] = mk(1'b1,1'b0,1'b0,15'h0000,8'h00,1'b1,1'b1,15'h0030,8'h11, 1'b0,1'b1,1'b0,1'b1,1'b1,15'h0030,8'h11,8'h00,1'b0,8'h5C);
        vecs[9] = mk(1'b1,1'b0,1'b0,15'h0000,8'h00,1'b0,1'b0,15'h0000,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,15'h0000,8'h00,8'h00,1'b0,8'h5C);

        drive(1'b0,1'b0,1'b0,15'h0,8'h0,1'b0,1'b0,15'h0,8'h0);
        next_cycle();

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rst, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].cdo,
                  vecs[i].dreq, vecs[i].dwe, vecs[i].daddr, vecs[i].dwd);
            #4;
            check($sformatf("v%0d core_stall", i), 32'(core_stall), 32'(vecs[i].stall));
            check($sformatf("v%0d dma_gnt", i), 32'(dma_gnt), 32'(vecs[i].gnt));
            check($sformatf("v%0d mem_enable_read", i), 32'(mem_enable_read), 32'(vecs[i].mer));
            check($sformatf("v%0d mem_enable_write", i), 32'(mem_enable_write), 32'(vecs[i].mew));
            check($sformatf("v%0d mem_rw", i), 32'(mem_rw), 32'(vecs[i].rw));
            check($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].maddr));
            check($sformatf("v%0d mem_data_out", i), 32'(mem_data_out), 32'(vecs[i].mdo));
            check($sformatf("v%0d core_data_in", i), 32'(core_data_in), 32'(vecs[i].cdi));
            check($sformatf("v%0d dma_rvalid", i), 32'(dma_rvalid), 32'(vecs[i].rvalid));
            check($sformatf("v%0d dma_rdata", i), 32'(dma_rdata), 32'(vecs[i].rdata));
            next_cycle();
        end
        check("mem08 after dual-enable write", 32'(mem[15'h0008]), 32'h3E);
        check("mem30 after dma write", 32'(mem[15'h0030]), 32'h11);

        // Starvation: 4 denials, 4-beat window, then core serviced again.
        for (int c = 1; c <= 10; c++) begin
            logic eg;
            eg = (c >= 5) && (c <= 8);
            drive(1'b1,1'b1,1'b0,15'h0003,8'h00,1'b1,1'b1,15'h0020,8'h77);
            #4;
            check($sformatf("starve c%0d dma_gnt", c), 32'(dma_gnt), 32'(eg));
            check($sformatf("starve c%0d core_stall", c), 32'(core_stall), 32'(eg));
            check($sformatf("starve c%0d mem_enable_write", c), 32'(mem_enable_write), 32'(eg));
            check($sformatf("starve c%0d mem_addr", c), 32'(mem_addr), eg ? 32'h20 : 32'h03);
            check($sformatf("starve c%0d core_data_in", c), 32'(core_data_in), eg ? 32'h00 : 32'hA0);
            next_cycle();
        end
        drive(1'b1,1'b0,1'b0,15'h0,8'h0,1'b0,1'b0,15'h0,8'h0);
        next_cycle();
        check("mem20 after window write", 32'(mem[15'h0020]), 32'h77);

        // Window ended by an idle cycle; core then serviced without stall.
        for (int c = 1; c <= 5; c++) begin
            drive(1'b1,1'b1,1'b0,15'h0003,8'h00,1'b1,1'b0,15'h0010,8'h00);
            #4;
            check($sformatf("idle-exit c%0d dma_gnt", c), 32'(dma_gnt), 32'(c == 5));
            check($sformatf("idle-exit c%0d core_stall", c), 32'(core_stall), 32'(c == 5));
            next_cycle();
        end
        drive(1'b1,1'b0,1'b0,15'h0,8'h0,1'b0,1'b0,15'h0,8'h0);
        #4;
        check("idle-exit idle dma_gnt", 32'(dma_gnt), 32'h0);
        check("idle-exit idle mem_enable_read", 32'(mem_enable_read), 32'h0);
        check("idle-exit dma_rvalid", 32'(dma_rvalid), 32'h1);
        check("idle-exit dma_rdata", 32'(dma_rdata), 32'h5C);
        next_cycle();
        drive(1'b1,1'b1,1'b0,15'h0003,8'h00,1'b0,1'b0,15'h0,8'h0);
        #4;
        check("after-window core_stall", 32'(core_stall), 32'h0);
        check("after-window mem_enable_read", 32'(mem_enable_read), 32'h1);
        check("after-window core_data_in", 32'(core_data_in), 32'hA0);
        check("after-window dma_rvalid", 32'(dma_rvalid), 32'h0);
        next_cycle();

        // Reset in the middle of a window aborts it.
        for (int c = 1; c <= 5; c++) begin
            drive(1'b1,1'b1,1'b0,15'h0003,8'h00,1'b1,1'b1,15'h0040,8'h22);
            #4;
            check($sformatf("rst-abort c%0d dma_gnt", c), 32'(dma_gnt), 32'(c == 5));
            next_cycle();
        end
        drive(1'b0,1'b1,1'b0,15'h0003,8'h00,1'b1,1'b1,15'h0040,8'h22);
        #4;
        check("in-reset dma_gnt", 32'(dma_gnt), 32'h0);
        check("in-reset core_stall", 32'(core_stall), 32'h0);
        check("in-reset mem_enable_write", 32'(mem_enable_write), 32'h0);
        check("in-reset mem_addr", 32'(mem_addr), 32'h0);
        check("in-reset mem_data_out", 32'(mem_data_out), 32'h0);
        check("in-reset core_data_in", 32'(core_data_in), 32'h0);
        next_cycle();
        for (int c = 1; c <= 3; c++) begin
            drive(1'b1,1'b1,1'b0,15'h0003,8'h00,1'b1,1'b1,15'h0040,8'h22);
            #4;
            check($sformatf("post-reset c%0d dma_gnt", c), 32'(dma_gnt), 32'h0);
            check($sformatf("post-reset c%0d core_stall", c), 32'(core_stall), 32'h0);
            check($sformatf("post-reset c%0d core_data_in", c), 32'(core_data_in), 32'hA0);
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
